// File: rtl/imem_writer_if.sv
// Load-side stream and byte-write bus of the instruction memory writer.
// The loader drives through master; the writer attaches through slave.
interface imem_writer_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] word_count;
    logic                  in_valid;
    logic [31:0]           in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output start, base_addr, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow
    );

    modport slave (
        input  start, base_addr, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow
    );
endinterface

// File: rtl/imem_writer.sv
// Serialises 32-bit instruction words into MSB-first byte writes at ascending
// addresses, stopping (with sticky overflow) rather than wrapping past the top.
module imem_writer #(
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst,
    imem_writer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           shift_q, shift_d;
    logic                  overflow_q, overflow_d;
    logic                  last_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            overflow_q  <= overflow_d;
        end
    end

    // Final byte of the whole load: the top address may be written then without overflow.
    assign last_byte = (idx_q == 2'd3) && (remaining_q == ONE);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        overflow_d    = overflow_q;
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ptr_d       = bus.base_addr;
                    remaining_d = bus.word_count;
                    overflow_d  = 1'b0;
                    state_d     = (bus.word_count == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    shift_d = bus.in_data;
                    idx_d   = 2'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = ptr_q;
                bus.mem_wdata = shift_q[31:24];
                shift_d       = {shift_q[23:0], 8'h00};
                ptr_d         = ptr_q + ONE;
                idx_d         = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    remaining_d = remaining_q - ONE;
                end
                if ((ptr_q == LAST_ADDR) && !last_byte) begin
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (idx_q == 2'd3) begin
                    state_d = (remaining_q == ONE) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_imem_writer.sv
// Directed bench for imem_writer: a byte-stream model predicts every memory
// write, a per-cycle monitor checks the bus, and literal checks pin timing.
module tb_imem_writer;
    localparam int MEM_SIZE = 64;
    localparam int AW       = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_writer_if #(.ADDR_WIDTH(AW)) bus ();

    imem_writer #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [7:0]  mem_model[MEM_SIZE];
    logic [7:0]  mem_dut[MEM_SIZE];
    logic [31:0] load_words[4];
    logic        plan_ovf;
    int          writes_to_zero = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the byte stream a load must produce, stopping at the top of memory.
    task automatic plan_load(input int base, input int count);
        int  a;
        bit  stop;
        a        = base;
        stop     = 0;
        plan_ovf = 1'b0;
        for (int w = 0; w < count && !stop; w++) begin
            for (int b = 0; b < 4 && !stop; b++) begin
                exp_addr.push_back(a);
                exp_data.push_back(load_words[w][31-8*b -: 8]);
                mem_model[a] = load_words[w][31-8*b -: 8];
                if (a == MEM_SIZE - 1 && !(w == count - 1 && b == 3)) begin
                    stop     = 1;
                    plan_ovf = 1'b1;
                end
                a++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) begin
            check("write_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
                check("wr_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
                check("wr_data", 32'(bus.mem_wdata), 32'(exp_data.pop_front()));
            end
            check("ready_in_write", 32'(bus.in_ready), 32'd0);
            mem_dut[bus.mem_addr] = bus.mem_wdata;
            if (bus.mem_addr == '0) writes_to_zero++;
        end else begin
            check("idle_addr", 32'(bus.mem_addr), 32'd0);
            check("idle_data", 32'(bus.mem_wdata), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int base, input int count);
        bus.start      = 1'b1;
        bus.base_addr  = AW'(base);
        bus.word_count = AW'(count);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input int stall);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_reached", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_ready", 32'(bus.in_ready), 32'd1);
            check("stall_we", 32'(bus.mem_we), 32'd0);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            tick();
        end
        check(name, 32'(lat), 32'(exp_lat));
        if (lat >= 0) begin
            tick();
            check({name, "_pulse"}, 32'(bus.done), 32'd0);
            check({name, "_idle"}, 32'(bus.busy), 32'd0);
        end
    endtask

    function automatic logic [31:0] read_word(input int a);
        return {mem_dut[a], mem_dut[a+1], mem_dut[a+2], mem_dut[a+3]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem_model[i] = 8'h00;
            mem_dut[i]   = 8'h00;
        end
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'hFFFF_FFFF;
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_ready", 32'(bus.in_ready), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);

        // 1: single word at address 0
        load_words[0] = 32'h0050_0093;
        plan_load(0, 1);
        start_load(0, 1);
        check("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        send_word(load_words[0], 0);
        wait_done("t1_done_lat", 4);
        check("t1_read_word", read_word(0), 32'h0050_0093);
        check("t1_byte1", 32'(mem_dut[1]), 32'h50);
        check("t1_drained", 32'(exp_addr.size()), 32'd0);

        // 2: two words with a 3-cycle stall between them
        load_words[0] = 32'h1122_3344;
        load_words[1] = 32'hA5B6_C7D8;
        plan_load(0, 2);
        start_load(0, 2);
        send_word(load_words[0], 0);
        send_word(load_words[1], 3);
        wait_done("t2_done_lat", 4);
        check("t2_word0", read_word(0), 32'h1122_3344);
        check("t2_word1", read_word(4), 32'hA5B6_C7D8);
        check("t2_drained", 32'(exp_addr.size()), 32'd0);

        // 3: zero-length load
        start_load(5, 0);
        check("t3_done_now", 32'(bus.done), 32'd1);
        check("t3_ovf", 32'(bus.overflow), 32'd0);
        tick();
        check("t3_pulse", 32'(bus.done), 32'd0);
        check("t3_idle", 32'(bus.busy), 32'd0);

        // 4: load running off the top of memory
        writes_to_zero = 0;
        load_words[0] = 32'hDEAD_BEEF;
        plan_load(62, 1);
        check("t4_model_ovf", 32'(plan_ovf), 32'd1);
        check("t4_model_len", 32'(exp_addr.size()), 32'd2);
        start_load(62, 1);
        send_word(load_words[0], 0);
        check("t4_ovf_pending", 32'(bus.overflow), 32'd0);
        wait_done("t4_done_lat", 2);
        check("t4_ovf", 32'(bus.overflow), 32'(plan_ovf));
        tick();
        check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
        check("t4_top_bytes", {16'h0, mem_dut[62], mem_dut[63]}, 32'h0000_DEAD);
        check("t4_no_wrap", 32'(writes_to_zero), 32'd0);
        check("t4_drained", 32'(exp_addr.size()), 32'd0);
        for (int i = 0; i < MEM_SIZE; i++) check("image", 32'(mem_dut[i]), 32'(mem_model[i]));

        // 6: start during WRITE is ignored
        load_words[0] = 32'h1357_9BDF;
        plan_load(20, 1);
        start_load(20, 1);
        check("t6_ovf_cleared", 32'(bus.overflow), 32'd0);
        send_word(load_words[0], 0);
        bus.start      = 1'b1;
        bus.base_addr  = AW'(40);
        bus.word_count = AW'(3);
        tick();
        bus.start = 1'b0;
        wait_done("t6_done_lat", 3);
        check("t6_word", read_word(20), 32'h1357_9BDF);
        check("t6_drained", 32'(exp_addr.size()), 32'd0);

        // 5: reset during the third byte write, then a clean load
        load_words[0] = 32'h0102_0304;
        plan_load(8, 1);
        start_load(8, 1);
        send_word(load_words[0], 0);
        tick();
        tick();
        check("t5_in_write", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        #1;
        check("t5_rst_we", 32'(bus.mem_we), 32'd0);
        check("t5_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("t5_rst_data", 32'(bus.mem_wdata), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_partial", {16'h0, mem_dut[8], mem_dut[9]}, 32'h0000_0102);
        tick();
        rst = 1'b0;
        tick();
        load_words[0] = 32'hCAFE_F00D;
        plan_load(16, 1);
        start_load(16, 1);
        send_word(load_words[0], 0);
        wait_done("t5_done_lat", 4);
        check("t5_word", read_word(16), 32'hCAFE_F00D);
        check("t5_drained", 32'(exp_addr.size()), 32'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
